// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device-side responder for the DB15 serial joystick link.
// On LOAD it latches ~{joy_2, joy_1}. It then shifts out one active-low bit
// on each CLK rising edge, starting with joy_1[0].
// Optional macro JOY_DB15_TX_FILTER_EN adds a glitch filter of FILTER_LEN
// samples on LOAD and CLK, placed after the synchronizers.
module joy_db15_tx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joy_1,
  input  logic [15:0] joy_2,
  input  logic        joy_load,
  input  logic        joy_clk,
  output logic        joy_data,
  output logic        busy,
  output logic        frame_done,
  output logic        aborted
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic load_s1_q, load_s2_q, clk_s1_q, clk_s2_q;
  logic load_acc, clk_acc;

  // Two-flop synchronizers for the asynchronous reader strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_s1_q <= 1'b1;
      load_s2_q <= 1'b1;
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
    end else begin
      // NOTE: state is written with <= so every flop samples pre-edge values.
      load_s1_q <= joy_load;
      load_s2_q <= load_s1_q;
      clk_s1_q  <= joy_clk;
      clk_s2_q  <= clk_s1_q;
    end
  end

`ifdef JOY_DB15_TX_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);

  logic          load_acc_q, load_acc_d, clk_acc_q, clk_acc_d;
  logic [FW-1:0] load_fcnt_q, load_fcnt_d, clk_fcnt_q, clk_fcnt_d;

  // The accepted level follows a synced input only after FILTER_LEN differing samples in a row.
  always_comb begin
    load_acc_d  = load_acc_q;
    load_fcnt_d = '0;
    if (load_s2_q != load_acc_q) begin
      if (load_fcnt_q == F_LAST) load_acc_d  = load_s2_q;
      else                       load_fcnt_d = load_fcnt_q + 1'b1;
    end
    clk_acc_d  = clk_acc_q;
    clk_fcnt_d = '0;
    if (clk_s2_q != clk_acc_q) begin
      if (clk_fcnt_q == F_LAST) clk_acc_d  = clk_s2_q;
      else                      clk_fcnt_d = clk_fcnt_q + 1'b1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_acc_q  <= 1'b1;
      clk_acc_q   <= 1'b0;
      load_fcnt_q <= '0;
      clk_fcnt_q  <= '0;
    end else begin
      load_acc_q  <= load_acc_d;
      clk_acc_q   <= clk_acc_d;
      load_fcnt_q <= load_fcnt_d;
      clk_fcnt_q  <= clk_fcnt_d;
    end
  end

  assign load_acc = load_acc_q;
  assign clk_acc  = clk_acc_q;
`else
  assign load_acc = load_s2_q;
  assign clk_acc  = clk_s2_q;
`endif

  state_e      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        clk_prev_q;
  logic        joy_data_q, joy_data_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        aborted_q, aborted_d;
  logic        clk_rise;
  logic [31:0] par;

  assign clk_rise = clk_acc & ~clk_prev_q;
  assign par      = ~{joy_2, joy_1};

  // Frame FSM: LOAD overrides everything, SHIFT consumes CLK edges or times out.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d      = state_q;
    sr_d         = sr_q;
    idx_d        = idx_q;
    tcnt_d       = '0;
    frame_done_d = 1'b0;
    aborted_d    = 1'b0;
    if (!load_acc) begin
      state_d   = S_LOAD;
      sr_d      = par;
      idx_d     = '0;
      aborted_d = (state_q == S_SHIFT);
    end else begin
      unique case (state_q)
        S_LOAD:  state_d = S_SHIFT;
        S_SHIFT: begin
          if (clk_rise) begin
            sr_d  = {1'b1, sr_q[31:1]};
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd31) begin
              state_d      = S_DONE;
              frame_done_d = 1'b1;
            end
          end else if (tcnt_q == TO_LAST) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
          end else begin
            tcnt_d = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
    busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT);
    joy_data_d = busy_d ? sr_d[0] : 1'b1;
  end

  // Registered FSM state, shift register and outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sr_q         <= '1;
      idx_q        <= '0;
      tcnt_q       <= '0;
      clk_prev_q   <= 1'b0;
      joy_data_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      idx_q        <= idx_d;
      tcnt_q       <= tcnt_d;
      clk_prev_q   <= clk_acc;
      joy_data_q   <= joy_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign joy_data   = joy_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign aborted    = aborted_q;

endmodule
